// File: rtl/hazard_unit.sv
// Pipeline hazard controller: EX operand forwarding, load-use and branch stalls,
// and a front-end freeze while a multi-cycle divide runs. Optional macro: HAZARD_BRANCH_FWD_EN.
module hazard_unit #(
  parameter int DIV_CYCLES = 32,
  parameter int AW         = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rs_d,
  input  logic [AW-1:0] rt_d,
  input  logic          branch_d,
  input  logic [AW-1:0] rs_e,
  input  logic [AW-1:0] rt_e,
  input  logic [AW-1:0] writereg_e,
  input  logic          regwrite_e,
  input  logic          memtoreg_e,
  input  logic [AW-1:0] writereg_m,
  input  logic          regwrite_m,
  input  logic          memtoreg_m,
  input  logic          link_m,
  input  logic [AW-1:0] writereg_w,
  input  logic          regwrite_w,
  input  logic          div_start_e,
  output logic [1:0]    forward_a_e,
  output logic [1:0]    forward_b_e,
  output logic          forward_a_d,
  output logic          forward_b_d,
  output logic          stall_f,
  output logic          stall_d,
  output logic          stall_e,
  output logic          flush_e,
  output logic          flush_m,
  output logic          div_busy,
  output logic          div_done
);

  localparam int CW = $clog2(DIV_CYCLES);

  typedef enum logic {IDLE, BUSY} div_state_t;

  div_state_t    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          div_stall;
  logic          lwstall, brstall, hz;

  // MEM beats WB; register 0 is hard-wired and never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [AW-1:0] src,
    input logic [AW-1:0] wm, input logic rwm, input logic lm,
    input logic [AW-1:0] ww, input logic rww
  );
    if (src != '0 && rwm && wm == src) return lm ? 2'b11 : 2'b10;
    if (src != '0 && rww && ww == src) return 2'b01;
    return 2'b00;
  endfunction

  assign forward_a_e = fwd_sel(rs_e, writereg_m, regwrite_m, link_m, writereg_w, regwrite_w);
  assign forward_b_e = fwd_sel(rt_e, writereg_m, regwrite_m, link_m, writereg_w, regwrite_w);

  assign lwstall = memtoreg_e & regwrite_e & (writereg_e != '0) &
                   ((writereg_e == rs_d) | (writereg_e == rt_d));

`ifdef HAZARD_BRANCH_FWD_EN
  logic br_dep_e, br_dep_m;

  assign forward_a_d = (rs_d != '0) & regwrite_m & (writereg_m == rs_d);
  assign forward_b_d = (rt_d != '0) & regwrite_m & (writereg_m == rt_d);

  assign br_dep_e = regwrite_e & (writereg_e != '0) &
                    ((writereg_e == rs_d) | (writereg_e == rt_d));
  assign br_dep_m = memtoreg_m & (writereg_m != '0) &
                    ((writereg_m == rs_d) | (writereg_m == rt_d));
  assign brstall  = branch_d & (br_dep_e | br_dep_m);
`else
  // Branches resolve in execute, so the decode-side inputs are intentionally unused.
  logic unused_branch;
  assign unused_branch = ^{branch_d, memtoreg_m};
  assign forward_a_d   = 1'b0;
  assign forward_b_d   = 1'b0;
  assign brstall       = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // NOTE: every output of this block is given a default first, so no path leaves
  // a variable unassigned and no latch can be inferred.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    div_stall = 1'b0;
    div_done  = 1'b0;
    unique case (state)
      IDLE: begin
        if (div_start_e) begin
          state_nx  = BUSY;
          cnt_nx    = CW'(DIV_CYCLES - 1);
          div_stall = 1'b1;
        end
      end
      BUSY: begin
        // div_start_e is the same held instruction here, so it is ignored.
        if (cnt != '0) begin
          cnt_nx    = cnt - CW'(1);
          div_stall = 1'b1;
        end else begin
          state_nx  = IDLE;
          div_done  = 1'b1;
        end
      end
    endcase
  end

  assign div_busy = (state == BUSY);

  assign hz      = lwstall | brstall;
  assign stall_f = hz | div_stall;
  assign stall_d = hz | div_stall;
  assign stall_e = div_stall;
  assign flush_m = div_stall;
  // A held ID-EX register must not also be flushed, so the divide freeze wins.
  assign flush_e = hz & ~div_stall;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit (DIV_CYCLES=4); covers both
// HAZARD_BRANCH_FWD_EN builds.
module tb_hazard_unit;

  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rs_d, rt_d, rs_e, rt_e, writereg_e, writereg_m, writereg_w;
  logic          branch_d, regwrite_e, memtoreg_e, regwrite_m, memtoreg_m, link_m;
  logic          regwrite_w, div_start_e;
  logic [1:0]    forward_a_e, forward_b_e;
  logic          forward_a_d, forward_b_d, stall_f, stall_d, stall_e;
  logic          flush_e, flush_m, div_busy, div_done;

  int n_checks = 0;
  int n_passed = 0;

  hazard_unit #(.DIV_CYCLES(4), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .rs_d(rs_d), .rt_d(rt_d), .branch_d(branch_d),
    .rs_e(rs_e), .rt_e(rt_e),
    .writereg_e(writereg_e), .regwrite_e(regwrite_e), .memtoreg_e(memtoreg_e),
    .writereg_m(writereg_m), .regwrite_m(regwrite_m), .memtoreg_m(memtoreg_m),
    .link_m(link_m),
    .writereg_w(writereg_w), .regwrite_w(regwrite_w),
    .div_start_e(div_start_e),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .forward_a_d(forward_a_d), .forward_b_d(forward_b_d),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
    .flush_e(flush_e), .flush_m(flush_m),
    .div_busy(div_busy), .div_done(div_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_passed++;
  endtask

  task automatic clear_inputs();
    rs_d = '0; rt_d = '0; branch_d = 0; rs_e = '0; rt_e = '0;
    writereg_e = '0; regwrite_e = 0; memtoreg_e = 0;
    writereg_m = '0; regwrite_m = 0; memtoreg_m = 0; link_m = 0;
    writereg_w = '0; regwrite_w = 0; div_start_e = 0;
  endtask

  // Divide of 4 cycles: stall for cycles 0..3, done pulse on cycle 4, then idle.
  task automatic run_divide(input string tag);
    logic [4:0] exp_stall, exp_done, exp_busy;
    exp_stall = 5'b01111;
    exp_done  = 5'b10000;
    exp_busy  = 5'b11110;
    @(posedge clk); #1;
    div_start_e = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("%s stall_e c%0d", tag, i), 32'(stall_e),  32'(exp_stall[i]));
      check($sformatf("%s stall_f c%0d", tag, i), 32'(stall_f),  32'(exp_stall[i]));
      check($sformatf("%s done c%0d",    tag, i), 32'(div_done), 32'(exp_done[i]));
      check($sformatf("%s busy c%0d",    tag, i), 32'(div_busy), 32'(exp_busy[i]));
      @(posedge clk); #1;
    end
    div_start_e = 0;
    #1;
    check({tag, " idle after"}, 32'(div_busy), 32'd0);
    check({tag, " no stall after"}, 32'(stall_e), 32'd0);
  endtask

  initial begin
    int done_seen;
    clear_inputs();
    rst = 1;
    #12;
    check("reset busy",  32'(div_busy), 32'd0);
    check("reset done",  32'(div_done), 32'd0);
    check("reset stall", 32'(stall_f),  32'd0);
    check("reset fwd_a", 32'(forward_a_e), 32'd0);
    check("reset flush", 32'(flush_e),  32'd0);
    rst = 0;

    // MEM forwarding, with and without link
    writereg_m = 3; regwrite_m = 1; rs_e = 3; #1;
    check("mem fwd_a", 32'(forward_a_e), 32'b10);
    check("mem fwd_b idle", 32'(forward_b_e), 32'b00);
    link_m = 1; rt_e = 3; #1;
    check("link fwd_a", 32'(forward_a_e), 32'b11);
    check("link fwd_b", 32'(forward_b_e), 32'b11);
    link_m = 0; rt_e = 0;

    // MEM over WB priority, WB only, register 0
    writereg_w = 3; regwrite_w = 1; #1;
    check("mem over wb", 32'(forward_a_e), 32'b10);
    regwrite_m = 0; #1;
    check("wb fwd_a", 32'(forward_a_e), 32'b01);
    rt_e = 3; #1;
    check("wb fwd_b", 32'(forward_b_e), 32'b01);
    clear_inputs();
    rs_e = 0; writereg_w = 0; regwrite_w = 1; writereg_m = 0; regwrite_m = 1; #1;
    check("r0 fwd_a", 32'(forward_a_e), 32'b00);
    clear_inputs();
    rs_e = 4; writereg_m = 3; regwrite_m = 1; #1;
    check("no match fwd", 32'(forward_a_e), 32'b00);
    clear_inputs();

    // Load-use: lw $5 in E, consumer rs_d=5 in D
    memtoreg_e = 1; regwrite_e = 1; writereg_e = 5; rs_d = 5; #1;
    check("lw stall_f", 32'(stall_f), 32'd1);
    check("lw stall_d", 32'(stall_d), 32'd1);
    check("lw flush_e", 32'(flush_e), 32'd1);
    check("lw stall_e", 32'(stall_e), 32'd0);
    check("lw flush_m", 32'(flush_m), 32'd0);
    rs_d = 0; rt_d = 5; #1;
    check("lw rt stall", 32'(stall_f), 32'd1);
    // bubble in E, load in M: consumer released
    clear_inputs();
    rs_d = 5; writereg_m = 5; regwrite_m = 1; memtoreg_m = 1; #1;
    check("lw release", 32'(stall_f), 32'd0);
    check("lw release flush", 32'(flush_e), 32'd0);
    // load in W, consumer in E
    clear_inputs();
    rs_e = 5; writereg_w = 5; regwrite_w = 1; #1;
    check("lw wb fwd", 32'(forward_a_e), 32'b01);
    clear_inputs();
    memtoreg_e = 1; regwrite_e = 1; writereg_e = 0; rs_d = 0; #1;
    check("lw r0 no stall", 32'(stall_f), 32'd0);
    clear_inputs();

    run_divide("div1");

    // Reset during BUSY with cnt=2
    @(posedge clk); #1;
    div_start_e = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre-rst busy", 32'(div_busy), 32'd1);
    memtoreg_e = 1; regwrite_e = 1; writereg_e = 6; rs_d = 6; #1;
    check("div wins flush_e", 32'(flush_e), 32'd0);
    check("div lw stall_f",   32'(stall_f), 32'd1);
    check("div flush_m",      32'(flush_m), 32'd1);
    clear_inputs();
    #1;
    rst = 1; #1;
    check("async rst busy", 32'(div_busy), 32'd0);
    check("async rst done", 32'(div_done), 32'd0);
    check("async rst stall", 32'(stall_e), 32'd0);
    @(posedge clk); #1;
    rst = 0;
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (div_done) done_seen++;
      @(posedge clk); #1;
    end
    check("no done after abort", 32'(done_seen), 32'd0);
    run_divide("div2");

    // Decode-stage branch hazard
    clear_inputs();
    branch_d = 1; rs_d = 7; writereg_e = 7; regwrite_e = 1; #1;
`ifdef HAZARD_BRANCH_FWD_EN
    check("br stall_f", 32'(stall_f), 32'd1);
    check("br flush_e", 32'(flush_e), 32'd1);
    regwrite_e = 0; writereg_e = 0; writereg_m = 7; regwrite_m = 1; #1;
    check("br release", 32'(stall_f), 32'd0);
    check("br fwd_a_d", 32'(forward_a_d), 32'd1);
    check("br fwd_b_d", 32'(forward_b_d), 32'd0);
    memtoreg_m = 1; #1;
    check("br load in M stall", 32'(stall_f), 32'd1);
`else
    check("br no stall", 32'(stall_f), 32'd0);
    regwrite_e = 0; writereg_e = 0; writereg_m = 7; regwrite_m = 1; #1;
    check("br fwd_a_d off", 32'(forward_a_d), 32'd0);
    check("br fwd_b_d off", 32'(forward_b_d), 32'd0);
`endif
    clear_inputs();

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
